// File: rtl/cv32e41s_pkg.sv
// Shared definitions for the security-flag controller: FSM state encoding,
// minor-counter limit and its saturating increment.
package cv32e41s_pkg;

    // Every pair of encodings differs in at least two bits, so a single
    // upset cannot move the FSM into another legal state.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        CHECK  = 3'b011,
        COMMIT = 3'b101,
        ALERT  = 3'b110
    } sec_flag_state_e;

    localparam logic [1:0] SEC_FLAG_MINOR_MAX = 2'd3;

    function automatic logic [1:0] sec_flag_sat_inc(input logic [1:0] cnt);
        return (cnt == SEC_FLAG_MINOR_MAX) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/cv32e41s_sec_flag_cell.sv
// One hardened flag: primary flop (resets to 1) with an optional inverted
// shadow flop (resets to 0), present when CV32E41S_SEC_FLAG_SHADOW_EN is defined.
module cv32e41s_sec_flag_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic we_i,
    input  logic data_i,
    output logic flag_o,
    output logic mismatch_o
);

    logic primary_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primary_q <= 1'b1;
        end else if (we_i) begin
            primary_q <= data_i;
        end
    end

`ifdef CV32E41S_SEC_FLAG_SHADOW_EN
    logic shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 1'b0;
        end else if (we_i) begin
            shadow_q <= ~data_i;
        end
    end

    // Healthy cells always hold complementary values.
    assign mismatch_o = (primary_q == shadow_q);
`else
    assign mismatch_o = 1'b0;
`endif

    assign flag_o = primary_q;

endmodule

// File: rtl/cv32e41s_sec_flag_ctrl.sv
// Security flag bank controller: free locking, keyed clearing, minor-reject
// escalation and shadow integrity checking (CV32E41S_SEC_FLAG_SHADOW_EN).
module cv32e41s_sec_flag_ctrl
    import cv32e41s_pkg::*;
#(
    parameter int          NUM_FLAGS  = 4,
    parameter logic [7:0]  UNLOCK_KEY = 8'h5A,
    parameter int          IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Handshake: a write transfers on the rising edge where wr_valid_i and
    // wr_ready_o are both high; ready is high only in IDLE.
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic                 wr_data_i,
    input  logic [7:0]           wr_key_i,
    output logic [NUM_FLAGS-1:0] flags_o,
    output logic                 busy_o,
    output logic                 alert_minor_o,
    output logic                 alert_major_o
);

    localparam logic [IDX_W:0] NUM_FLAGS_L = (IDX_W+1)'(NUM_FLAGS);

    sec_flag_state_e       state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  data_q;
    logic [7:0]            key_q;
    logic [1:0]            minor_cnt_q;
    logic                  alert_minor_q;
    logic [1:0]            minor_cnt_inc;

    logic [NUM_FLAGS-1:0]  flag_val;
    logic [NUM_FLAGS-1:0]  mismatch;
    logic                  integrity_err;
    logic                  reject;

    assign integrity_err = |mismatch;
    assign reject        = ({1'b0, idx_q} >= NUM_FLAGS_L) ||
                           (!data_q && (key_q != UNLOCK_KEY));
    assign minor_cnt_inc = sec_flag_sat_inc(minor_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            data_q        <= 1'b1;
            key_q         <= '0;
            minor_cnt_q   <= '0;
            alert_minor_q <= 1'b0;
        end else begin
            alert_minor_q <= 1'b0;
            // An integrity failure overrides any write in flight.
            if (state_q != ALERT && integrity_err) begin
                state_q <= ALERT;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (wr_valid_i) begin
                            idx_q   <= wr_idx_i;
                            data_q  <= wr_data_i;
                            key_q   <= wr_key_i;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (reject) begin
                            alert_minor_q <= 1'b1;
                            minor_cnt_q   <= minor_cnt_inc;
                            state_q       <= (minor_cnt_inc == SEC_FLAG_MINOR_MAX) ? ALERT : IDLE;
                        end else begin
                            state_q <= COMMIT;
                        end
                    end
                    COMMIT:  state_q <= IDLE;
                    ALERT:   state_q <= ALERT;
                    // Illegal encodings fail safe.
                    default: state_q <= ALERT;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_FLAGS; i++) begin : gen_cell
        logic we;
        assign we = (state_q == COMMIT) && !integrity_err && (idx_q == IDX_W'(i));

        cv32e41s_sec_flag_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .we_i       (we),
            .data_i     (data_q),
            .flag_o     (flag_val[i]),
            .mismatch_o (mismatch[i])
        );
    end

    assign wr_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q == CHECK) || (state_q == COMMIT);
    assign alert_minor_o = alert_minor_q;
    assign alert_major_o = (state_q == ALERT);
    assign flags_o       = (state_q == ALERT) ? {NUM_FLAGS{1'b1}} : flag_val;

endmodule

// File: tb/tb_cv32e41s_sec_flag_ctrl.sv
// Bench for cv32e41s_sec_flag_ctrl: directed steps plus randomized writes
// checked against a flag/counter reference model.
module tb_cv32e41s_sec_flag_ctrl;

    localparam int         NUM_FLAGS = 4;
    localparam logic [7:0] KEY       = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [3:0] wr_idx_i = '0;
    logic       wr_data_i = 1'b1;
    logic [7:0] wr_key_i = '0;
    logic [3:0] flags_o;
    logic       busy_o;
    logic       alert_minor_o;
    logic       alert_major_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model
    bit m_flags[NUM_FLAGS];
    int m_minor;
    bit m_alert;

    always #5 clk = ~clk;

    cv32e41s_sec_flag_ctrl #(.NUM_FLAGS(NUM_FLAGS), .UNLOCK_KEY(KEY), .IDX_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_idx_i      (wr_idx_i),
        .wr_data_i     (wr_data_i),
        .wr_key_i      (wr_key_i),
        .flags_o       (flags_o),
        .busy_o        (busy_o),
        .alert_minor_o (alert_minor_o),
        .alert_major_o (alert_major_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags();
        logic [3:0] v;
        v = 4'hF;
        if (!m_alert)
            for (int i = 0; i < NUM_FLAGS; i++) v[i] = m_flags[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FLAGS; i++) m_flags[i] = 1'b1;
        m_minor = 0;
        m_alert = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_valid_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input int idx, input bit data, input logic [7:0] key);
        bit rej;
        @(negedge clk);
        if (m_alert) begin
            wr_valid_i = 1'b1; wr_idx_i = 4'(idx); wr_data_i = data; wr_key_i = key;
            check("alert_ready", wr_ready_o, 1'b0);
            @(negedge clk);
            wr_valid_i = 1'b0;
            check("alert_flags", flags_o, 4'hF);
            check("alert_busy", busy_o, 1'b0);
            check("alert_major", alert_major_o, 1'b1);
            return;
        end
        check("idle_ready", wr_ready_o, 1'b1);
        wr_valid_i = 1'b1; wr_idx_i = 4'(idx); wr_data_i = data; wr_key_i = key;
        @(negedge clk);
        wr_valid_i = 1'b0;
        check("t1_busy", busy_o, 1'b1);
        check("t1_ready", wr_ready_o, 1'b0);
        check("t1_minor", alert_minor_o, 1'b0);
        rej = (idx >= NUM_FLAGS) || (data == 1'b0 && key != KEY);
        if (rej) begin
            m_minor = (m_minor < 3) ? m_minor + 1 : 3;
            if (m_minor == 3) m_alert = 1'b1;
        end else begin
            m_flags[idx] = data;
        end
        @(negedge clk);
        if (rej) begin
            check("t2_minor", alert_minor_o, 1'b1);
            check("t2_major", alert_major_o, m_alert);
            check("t2_ready", wr_ready_o, !m_alert);
            check("t2_busy", busy_o, 1'b0);
        end else begin
            check("t2_busy", busy_o, 1'b1);
            check("t2_ready", wr_ready_o, 1'b0);
            check("t2_minor", alert_minor_o, 1'b0);
        end
        @(negedge clk);
        check("t3_flags", flags_o, exp_flags());
        check("t3_minor", alert_minor_o, 1'b0);
        check("t3_busy", busy_o, 1'b0);
    endtask

    task automatic rand_write(input int reject_1_in);
        int  idx;
        bit  data;
        logic [7:0] key;
        idx  = $urandom_range(0, NUM_FLAGS - 1);
        data = 1'($urandom_range(0, 1));
        key  = data ? 8'($urandom) : KEY;
        if (reject_1_in > 0 && $urandom_range(1, reject_1_in) == 1) begin
            if ($urandom_range(0, 1) == 1) idx = $urandom_range(NUM_FLAGS, 15);
            else begin data = 1'b0; key = KEY ^ 8'($urandom_range(1, 255)); end
        end
        do_write(idx, data, key);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        apply_reset();

        // Reset state
        @(negedge clk);
        check("rst_flags", flags_o, 4'hF);
        check("rst_ready", wr_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_minor", alert_minor_o, 1'b0);
        check("rst_major", alert_major_o, 1'b0);

        // Keyed clear of flag 2, then a bad-key clear of flag 1
        do_write(2, 1'b0, KEY);
        check("clear2_flags", flags_o, 4'b1011);
        do_write(1, 1'b0, 8'h00);
        check("badkey_flags", flags_o, 4'b1011);
        do_write(2, 1'b0, KEY);     // same value rewritten
        do_write(2, 1'b1, 8'h00);   // lock needs no key

        // Legal random writes
        for (int n = 0; n < 30; n++) rand_write(0);

        // Reset in the middle of a clear's COMMIT
        @(negedge clk);
        wr_valid_i = 1'b1; wr_idx_i = 4'd3; wr_data_i = 1'b0; wr_key_i = KEY;
        @(negedge clk);
        wr_valid_i = 1'b0;
        @(negedge clk);
        check("mid_commit_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rstmid_flags", flags_o, 4'hF);
        check("rstmid_ready", wr_ready_o, 1'b1);
        check("rstmid_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_cnt", dut.minor_cnt_q, 2'd0);
        check("rstmid_state_idle", wr_ready_o, 1'b1);

        // Random writes with occasional rejects until escalation (or not)
        for (int n = 0; n < 40; n++) rand_write(6);

        // Out-of-range index and bad keys escalate
        apply_reset();
        do_write(5, 1'b0, KEY);
        check("idx5_flags", flags_o, 4'hF);
        do_write(1, 1'b0, 8'h00);
        check("two_rej_major", alert_major_o, 1'b0);
        do_write(1, 1'b0, 8'h00);
        check("sat_major", alert_major_o, 1'b1);
        check("sat_ready", wr_ready_o, 1'b0);
        do_write(0, 1'b0, KEY);

`ifdef CV32E41S_SEC_FLAG_SHADOW_EN
        // Shadow corruption while a clear of flag 0 is pending
        apply_reset();
        @(negedge clk);
        wr_valid_i = 1'b1; wr_idx_i = 4'd0; wr_data_i = 1'b0; wr_key_i = KEY;
        @(negedge clk);
        wr_valid_i = 1'b0;
        check("sh_t1_busy", busy_o, 1'b1);
        force dut.gen_cell[0].u_cell.shadow_q = 1'b1;
        @(negedge clk);
        check("sh_major", alert_major_o, 1'b1);
        check("sh_flags", flags_o, 4'hF);
        check("sh_busy", busy_o, 1'b0);
        @(negedge clk);
        release dut.gen_cell[0].u_cell.shadow_q;
        check("sh_dropped", dut.gen_cell[0].u_cell.primary_q, 1'b1);
        check("sh_sticky", alert_major_o, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
